// File: rtl/ps2_pkg.sv
// ps2_pkg: shared decoder state encoding, event layout and PS/2 protocol byte constants.
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, PRE_E0, PRE_F0, PRE_E0F0, PAUSE_SKIP} state_e;
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ev_t;
  localparam logic [7:0] E0 = 8'hE0;
  localparam logic [7:0] F0 = 8'hF0;
  localparam logic [7:0] E1 = 8'hE1;
  localparam logic [7:0] AA = 8'hAA;
  localparam logic [7:0] FA = 8'hFA;
  localparam logic [7:0] FE = 8'hFE;
  localparam logic [7:0] EE = 8'hEE;
  localparam logic [2:0] PAUSE_LEN = 3'd7;
  function automatic logic is_prefix(input logic [7:0] b);
    return b == E0 || b == F0 || b == E1;
  endfunction
  // Keyboard status replies that carry no key information.
  function automatic logic is_status(input logic [7:0] b);
    return b == AA || b == FA || b == FE || b == EE;
  endfunction
endpackage

// File: rtl/event_fifo.sv
// event_fifo: DEPTH-entry event queue; a push into a full queue only lands when a pop frees the slot.
module event_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [9:0] din,
  output logic [9:0] dout,
  output logic       full,
  output logic       empty
);
  logic [9:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;
  assign full    = cnt_q == (AW+1)'(DEPTH);
  assign empty   = cnt_q == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_q];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_q + AW'(do_pop);
      wr_q  <= wr_q + AW'(do_push);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/scancode_decoder.sv
// scancode_decoder: turns PS/2 set-2 byte streams into make/break key events queued in a FIFO.
module scancode_decoder
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic       frame_err,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       overflow,
  output logic       err
);
  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       emit, set_err, err_q, ovf_q, full, empty, pop;
  ev_t        ev, head;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (byte_valid && frame_err) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (byte_valid) begin
      case (state_q)
        IDLE: begin
          state_d = byte_in == E0 ? PRE_E0 : byte_in == F0 ? PRE_F0 : byte_in == E1 ? PAUSE_SKIP : IDLE;
          cnt_d   = byte_in == E1 ? PAUSE_LEN : cnt_q;
        end
        PRE_E0:     state_d = byte_in == F0 ? PRE_E0F0 : byte_in == E0 ? PRE_E0 : IDLE;
        PAUSE_SKIP: begin
          cnt_d   = cnt_q - 3'd1;
          state_d = cnt_q == 3'd1 ? IDLE : PAUSE_SKIP;
        end
        default:    state_d = IDLE;
      endcase
    end
  end
  always_comb begin
    emit    = 1'b0;
    set_err = byte_valid && frame_err;
    ev      = '{ext: 1'b0, brk: 1'b0, code: byte_in};
    if (byte_valid && !frame_err) begin
      case (state_q)
        IDLE: begin
          emit    = !is_prefix(byte_in) && !is_status(byte_in) && byte_in != 8'h00 && byte_in != 8'hFF;
          set_err = byte_in == 8'h00 || byte_in == 8'hFF;
        end
        PRE_E0: begin
          emit   = byte_in != E0 && byte_in != F0;
          ev.ext = 1'b1;
        end
        PRE_F0, PRE_E0F0: begin
          emit    = !is_prefix(byte_in);
          set_err = is_prefix(byte_in);
          ev.ext  = state_q == PRE_E0F0;
          ev.brk  = 1'b1;
        end
        PAUSE_SKIP: begin
          emit = cnt_q == 3'd1;
          ev   = '{ext: 1'b1, brk: 1'b0, code: E1};
        end
        default: ;
      endcase
    end
  end
  assign pop = ev_ready && !empty;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      err_q <= err_q || set_err;
      ovf_q <= ovf_q || (emit && full && !pop);
    end
  end
  event_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (emit),
    .pop   (pop),
    .din   (ev),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
  // Head fields are masked while empty so stale storage never shows on the outputs.
  assign ev_valid = !empty;
  assign ev_code  = empty ? 8'h00 : head.code;
  assign ev_ext   = !empty && head.ext;
  assign ev_break = !empty && head.brk;
  assign overflow = ovf_q;
  assign err      = err_q;
endmodule

// File: doc/scancode_decoder.md
SCANCODE_DECODER -- requirements
Module: scancode_decoder

Interface
REQ-001 The block SHALL expose parameter DEPTH, default 4, giving the event FIFO depth in entries (power of two, 2..16).
REQ-002 The block SHALL expose port clk  input  1  system clock; all state updates occur on its rising edge.
REQ-003 The block SHALL expose port rst  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL expose port byte_in  input  8  received PS/2 data byte, valid only when byte_valid=1.
REQ-005 The block SHALL expose port byte_valid  input  1  one-cycle strobe marking a completed frame from the upstream PS/2 receiver.
REQ-006 The block SHALL expose port frame_err  input  1  qualifies byte_valid; 1 = parity or stop-bit error on this byte.
REQ-007 The block SHALL expose port ev_code  output  8  key code of the FIFO head event.
REQ-008 The block SHALL expose port ev_ext  output  1  head event carried an E0 prefix.
REQ-009 The block SHALL expose port ev_break  output  1  head event is a key release (F0 prefix).
REQ-010 The block SHALL expose port ev_valid  output  1  FIFO non-empty.
REQ-011 The block SHALL expose port ev_ready  input  1  consumer accepts the head event when ev_valid=1.
REQ-012 The block SHALL expose port overflow  output  1  sticky: an event was dropped because the FIFO was full.
REQ-013 The block SHALL expose port err  output  1  sticky: a frame_err byte or an 8'h00/8'hFF keyboard error code was received.

Function
REQ-014 The decoder SHALL act only on cycles with byte_valid=1; bytes with frame_err=1 SHALL set err, return the decoder to IDLE and emit no event.
REQ-015 Decoder states SHALL be IDLE, PRE_E0, PRE_F0, PRE_E0F0 and PAUSE_SKIP.
REQ-016 IDLE: 8'hE0 -> PRE_E0; 8'hF0 -> PRE_F0; 8'hE1 -> PAUSE_SKIP with skip counter = 7; 8'hAA, 8'hFA, 8'hFE, 8'hEE SHALL be discarded (stay IDLE); 8'h00/8'hFF SHALL set err and be discarded; any other byte SHALL emit {code, ext=0, break=0}.
REQ-017 PRE_E0: 8'hF0 -> PRE_E0F0; 8'hE0 SHALL stay in PRE_E0; any other byte SHALL emit {code, ext=1, break=0} and return to IDLE.
REQ-018 PRE_F0: any byte other than E0/F0/E1 SHALL emit {code, ext=0, break=1} -> IDLE; E0/F0/E1 SHALL set err -> IDLE.
REQ-019 PRE_E0F0: any byte other than E0/F0/E1 SHALL emit {code, ext=1, break=1} -> IDLE; E0/F0/E1 SHALL set err -> IDLE.
REQ-020 PAUSE_SKIP SHALL decrement the counter on each valid byte without decoding it; on the byte that takes the counter to 0 it SHALL emit {8'hE1, ext=1, break=0} and return to IDLE.
REQ-021 An emitted event SHALL be pushed into the FIFO on the clock edge sampling the final byte; ev_valid SHALL be 1 in the following cycle (latency 1 cycle).
REQ-022 A pop SHALL occur on a rising edge where ev_valid=1 and ev_ready=1; ev_code/ev_ext/ev_break SHALL then present the next entry.
REQ-023 ev_ready while ev_valid=0 SHALL have no effect.
REQ-024 A push into a full FIFO without a simultaneous pop SHALL be dropped and SHALL set overflow; a push and pop in the same cycle when full SHALL both succeed with no overflow.
REQ-025 A push and pop in the same cycle when the FIFO holds one entry SHALL leave exactly one entry, the new event.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked with a log2(DEPTH)+1-bit count.
REQ-027 overflow and err SHALL remain set until reset.

Reset
REQ-028 While rst=1 the decoder SHALL be IDLE, skip counter 0, FIFO empty, and ev_valid, ev_code, ev_ext, ev_break, overflow and err SHALL all be 0.
REQ-029 Reset asserted mid-sequence, e.g. after E0 or inside PAUSE_SKIP, SHALL discard the partial sequence; the first byte after release SHALL be decoded from IDLE.

Structure
REQ-030 A shared package ps2_pkg SHALL hold the decoder state encoding and the constants E0, F0, E1, AA, FA, FE, EE and PAUSE_LEN=7.
REQ-031 The FIFO SHALL be a separate sub-module, event_fifo, 10 bits wide with DEPTH entries, with push/pop/full/empty ports.

Verification
REQ-032 Bytes 1C, F0, 1C -> events {1C,0,0} then {1C,0,1}; err=0.
REQ-033 Bytes E0, 75, E0, F0, 75 -> events {75,1,0} then {75,1,1}.
REQ-034 Bytes E1, 14, 77, E1, F0, 14, F0, 77 -> exactly one event {E1,1,0}, emitted on the 8th byte.
REQ-035 With ev_ready=0, six make codes 15..1A -> FIFO holds 15..18 and overflow=1; with ev_ready then held at 1, exactly 15, 16, 17, 18 are popped.
REQ-036 Bytes AA, FA, then 1C with frame_err=1, then 1C -> err=1 and one event {1C,0,0}.
REQ-037 Byte E0, then rst pulse, then 74 -> event {74,0,0}, with all outputs 0 during reset.
